// File: rtl/ex_muldiv_unit_pkg.sv
// Shared decode constants and FSM state encoding for the EX-stage RV32M unit.
package ex_muldiv_unit_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// One iteration of the multiplier (shift-add) or restoring divider (shift-subtract).
module ex_muldiv_unit_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic            in_bit,
  input  logic [XLEN-1:0] operand,
  input  logic            div_mode,
  output logic [XLEN-1:0] acc_next,
  output logic            out_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (in_bit ? {1'b0, operand} : '0);
    shifted  = {acc, in_bit};
    diff     = shifted - {1'b0, operand};
    acc_next = sum[XLEN:1];
    out_bit  = sum[0];
    // Divide: the shifted partial remainder is at most 33 bits; a clear borrow means it fits.
    if (div_mode) begin
      out_bit  = ~diff[XLEN];
      acc_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit; stalls the pipeline until the result is ready.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_ex,
  input  logic            kill_ex,
  input  logic [6:0]      opcode_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [6:0]      funct7_ex,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  state_t state, state_n;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   acc, lo, divisor, result_q;
  logic [2:0]        f3_q;
  logic              neg_hi, neg_lo, rv_q;
  logic              load, finish;

  logic              is_m, signed_a, signed_b, neg_a, neg_b, div_zero, ovf, fast;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res;

  logic [XLEN-1:0]   acc_n, lo_n, quo_fix, rem_fix, final_res;
  logic              step_bit;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign is_m = valid_ex & ~kill_ex & (opcode_ex == OP_RTYPE) & (funct7_ex == F7_MULDIV);

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3_ex)
      F3_MULH, F3_DIV, F3_REM: begin signed_a = 1'b1; signed_b = 1'b1; end
      F3_MULHSU:               signed_a = 1'b1;
      default: ;
    endcase
    neg_a    = signed_a & op_a[XLEN-1];
    neg_b    = signed_b & op_b[XLEN-1];
    a_mag    = neg_a ? -op_a : op_a;
    b_mag    = neg_b ? -op_b : op_b;
    div_zero = funct3_ex[2] & (op_b == '0);
    ovf      = funct3_ex[2] & ~funct3_ex[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    fast     = div_zero | ovf;
    // funct3[1] selects the remainder flavour of DIV/DIVU/REM/REMU.
    if (div_zero) fast_res = funct3_ex[1] ? op_a : '1;
    else          fast_res = funct3_ex[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  ex_muldiv_unit_muldiv_step #(.XLEN(XLEN)) u_muldiv_step (
    .acc      (acc),
    .in_bit   (f3_q[2] ? lo[XLEN-1] : lo[0]),
    .operand  (divisor),
    .div_mode (f3_q[2]),
    .acc_next (acc_n),
    .out_bit  (step_bit)
  );

  always_comb begin
    lo_n     = f3_q[2] ? {lo[XLEN-2:0], step_bit} : {step_bit, lo[XLEN-1:1]};
    prod     = {acc_n, lo_n};
    prod_fix = neg_hi ? -prod : prod;
    quo_fix  = neg_hi ? -lo_n : lo_n;
    rem_fix  = neg_lo ? -acc_n : acc_n;
    case (f3_q)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = quo_fix;
      F3_REM, F3_REMU:              final_res = rem_fix;
      default:                      final_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (is_m) begin
        load    = 1'b1;
        state_n = fast ? DONE : CALC;
      end
      CALC: begin
        if (kill_ex) state_n = IDLE;
        else if (count == CNT_W'(XLEN-1)) begin
          state_n = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      lo       <= '0;
      divisor  <= '0;
      f3_q     <= '0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state <= state_n;
      rv_q  <= 1'b0;
      if (load) begin
        acc     <= '0;
        lo      <= a_mag;
        divisor <= b_mag;
        f3_q    <= funct3_ex;
        count   <= '0;
        neg_hi  <= neg_a ^ neg_b;
        neg_lo  <= neg_a;
        if (fast) begin
          result_q <= fast_res;
          rv_q     <= 1'b1;
        end
      end else if (state == CALC) begin
        acc   <= acc_n;
        lo    <= lo_n;
        count <= count + 1'b1;
        if (finish) begin
          result_q <= final_res;
          rv_q     <= 1'b1;
        end
      end
    end
  end

  assign stall        = is_m & (state != DONE);
  assign busy         = (state == CALC);
  assign result       = result_q;
  assign result_valid = rv_q & ~kill_ex;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors with hand-computed results.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex, kill_ex;
  logic [6:0]  opcode_ex, funct7_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] op_a, op_b;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_ex     (valid_ex),
    .kill_ex      (kill_ex),
    .opcode_ex    (opcode_ex),
    .funct3_ex    (funct3_ex),
    .funct7_ex    (funct7_ex),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result_valid pulse must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: got result %h with no op pending", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    valid_ex  = v;
    opcode_ex = OP_RTYPE;
    funct7_ex = f7;
    funct3_ex = f3;
    op_a      = a;
    op_b      = b;
  endtask

  // Issues one instruction, measures how many cycles stall is held, then lets ID/EX advance.
  task automatic run_op(input string name, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall);
    int n;
    n = 0;
    drive(1'b1, f7, f3, a, b);
    if (f7 == F7_MULDIV) exp_q.push_back(exp);
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, n, exp_stall);
    if (f7 != F7_MULDIV) chk({name, "_no_valid"}, {31'b0, result_valid}, 32'd0);
    @(posedge clk);
    #1;
    valid_ex = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    kill_ex = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul",    F7_MULDIV, F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    @(negedge clk);
    chk("result_hold", result, 32'hFFFFFFEB);
    chk("valid_one_cycle", {31'b0, result_valid}, 32'd0);
    @(posedge clk); #1;

    run_op("mulhu",  F7_MULDIV, F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",   F7_MULDIV, F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu", F7_MULDIV, F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("div",    F7_MULDIV, F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    F7_MULDIV, F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   F7_MULDIV, F3_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   F7_MULDIV, F3_REMU,   32'd100,      32'd7,        32'd2,        33);
    run_op("divu0",  F7_MULDIV, F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu0",  F7_MULDIV, F3_REMU,   32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", F7_MULDIV, F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", F7_MULDIV, F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("add",    7'd0,      3'd0,      32'd1,        32'd2,        32'd0,        0);

    drive(1'b0, F7_MULDIV, F3_MUL, 32'd3, 32'd3);
    @(negedge clk);
    chk("bubble_stall", {31'b0, stall}, 32'd0);
    chk("bubble_valid", {31'b0, result_valid}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back: the DIV is presented on the edge right after the MUL's DONE cycle.
    run_op("b2b_mul", F7_MULDIV, F3_MUL, 32'd6,  32'd7, 32'd42, 33);
    run_op("b2b_div", F7_MULDIV, F3_DIV, 32'd42, 32'd5, 32'd8,  33);

    // Reset in the middle of an operation.
    drive(1'b1, F7_MULDIV, F3_MUL, 32'd9, 32'd9);
    repeat (11) @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_busy", {31'b0, busy}, 32'd0);
    chk("mid_reset_valid", {31'b0, result_valid}, 32'd0);
    chk("mid_reset_stall", {31'b0, stall}, 32'd1);
    valid_ex = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Kill at CALC iteration 5: aborts with no result.
    drive(1'b1, F7_MULDIV, F3_MUL, 32'd5, 32'd5);
    repeat (6) @(negedge clk);
    chk("pre_kill_busy", {31'b0, busy}, 32'd1);
    kill_ex = 1'b1;
    #1;
    chk("kill_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    kill_ex  = 1'b0;
    valid_ex = 1'b0;
    @(negedge clk);
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_valid", {31'b0, result_valid}, 32'd0);
    @(posedge clk); #1;

    run_op("post_kill_mul", F7_MULDIV, F3_MUL, 32'd12, 32'd11, 32'd132, 33);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
